// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: two single-entry buffers (ALU, load unit) share the one
// register-file write port, oldest entry first, with x0 writes discarded.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [31:0] pend_mask,
  output logic [7:0]  x0_drops
);

  logic        alu_full_q, alu_full_d;
  logic [4:0]  alu_rd_q, alu_rd_d;
  logic [31:0] alu_data_q, alu_data_d;
  logic        alu_age_q, alu_age_d;

  logic        mem_full_q, mem_full_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_age_q, mem_age_d;

  logic        we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;
  logic [7:0]  drops_q, drops_d;

  logic        alu_acc, mem_acc;
  logic        grant_alu, grant_mem, grant_any;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;
  logic [31:0] pend_d;

  // Ready depends only on the full flags, never on the incoming valid.
  assign alu_ready = ~alu_full_q;
  assign mem_ready = ~mem_full_q;
  assign alu_acc   = alu_valid & ~alu_full_q;
  assign mem_acc   = mem_valid & ~mem_full_q;

  // An age bit set means "this buffer was accepted before the other one";
  // equal ages (simultaneous acceptance) resolve in favour of the load unit.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full_q && mem_full_q) begin
      if (alu_age_q && !mem_age_q) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else if (alu_full_q) begin
      grant_alu = 1'b1;
    end else if (mem_full_q) begin
      grant_mem = 1'b1;
    end
  end

  assign grant_any  = grant_alu | grant_mem;
  assign grant_rd   = grant_alu ? alu_rd_q   : mem_rd_q;
  assign grant_data = grant_alu ? alu_data_q : mem_data_q;

  always_comb begin
    alu_full_d = alu_full_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    alu_age_d  = alu_age_q;
    if (grant_alu) begin
      alu_full_d = 1'b0;
      alu_age_d  = 1'b0;
    end
    if (alu_acc) begin
      alu_full_d = 1'b1;
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
      alu_age_d  = 1'b0;
    end else if (mem_acc && alu_full_q && !grant_alu) begin
      alu_age_d  = 1'b1;
    end
  end

  always_comb begin
    mem_full_d = mem_full_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    mem_age_d  = mem_age_q;
    if (grant_mem) begin
      mem_full_d = 1'b0;
      mem_age_d  = 1'b0;
    end
    if (mem_acc) begin
      mem_full_d = 1'b1;
      mem_rd_d   = mem_rd;
      mem_data_d = mem_data;
      mem_age_d  = 1'b0;
    end else if (alu_acc && mem_full_q && !grant_mem) begin
      mem_age_d  = 1'b1;
    end
  end

  // A granted x0 entry is consumed silently: the write port keeps its old
  // address/data and only the saturating drop counter moves.
  always_comb begin
    we3_d   = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    drops_d = drops_q;
    if (grant_any) begin
      if (grant_rd != 5'd0) begin
        we3_d = 1'b1;
        a3_d  = grant_rd;
        wd3_d = grant_data;
      end else if (drops_q != 8'hFF) begin
        drops_d = drops_q + 8'd1;
      end
    end
  end

  always_comb begin
    pend_d = '0;
    if (alu_full_q) pend_d[alu_rd_q] = 1'b1;
    if (mem_full_q) pend_d[mem_rd_q] = 1'b1;
    if (we3_q)      pend_d[a3_q]     = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      alu_age_q  <= 1'b0;
      mem_full_q <= 1'b0;
      mem_rd_q   <= '0;
      mem_data_q <= '0;
      mem_age_q  <= 1'b0;
      we3_q      <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      drops_q    <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      alu_age_q  <= alu_age_d;
      mem_full_q <= mem_full_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      mem_age_q  <= mem_age_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      drops_q    <= drops_d;
    end
  end

  assign we3       = we3_q;
  assign a3        = a3_q;
  assign wd3       = wd3_q;
  assign pend_mask = pend_d;
  assign x0_drops  = drops_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter: an ordered queue of pending
// entries predicts readiness, write order, pend_mask and the x0 drop count.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pend_mask;
  logic [7:0]  x0_drops;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .we3(we3), .a3(a3), .wd3(wd3), .pend_mask(pend_mask), .x0_drops(x0_drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isMem;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // pend holds accepted-but-ungranted entries in acceptance order; expQ holds
  // the register-file writes the monitor must see, in order.
  entry_t      pend[$];
  entry_t      expQ[$];
  int          expDrops = 0;
  logic [4:0]  inflightRd = '0;
  logic [4:0]  lastA3 = '0;
  logic [31:0] lastWd = '0;

  bit          aluWant = 0, memWant = 0;
  logic [4:0]  aluWRd = '0, memWRd = '0;
  logic [31:0] aluWData = '0, memWData = '0;
  int          aluPct = 0, memPct = 0;

  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit portBusy(input bit isMem);
    foreach (pend[i]) if (pend[i].isMem == isMem) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] pickRd();
    if ($urandom_range(7) == 0) return 5'd0;
    return 5'($urandom_range(31, 1));
  endfunction

  // Called just after a falling edge: check state left by the last rising
  // edge, drive inputs, then advance the model across the next rising edge.
  task automatic applyStimulus();
    logic [31:0] expMask;
    bit aluRdy, memRdy;
    entry_t g, n;
    expMask = '0;
    foreach (pend[i]) expMask[pend[i].rd] = 1'b1;
    expMask[inflightRd] = 1'b1;
    expMask[0] = 1'b0;
    checkOutput("alu_ready", 32'(alu_ready), 32'(!portBusy(1'b0)));
    checkOutput("mem_ready", 32'(mem_ready), 32'(!portBusy(1'b1)));
    checkOutput("pend_mask", pend_mask, expMask);
    checkOutput("x0_drops", 32'(x0_drops), 32'(expDrops));

    if (!aluWant && $urandom_range(99) < aluPct) begin
      aluWant = 1; aluWRd = pickRd(); aluWData = $urandom;
    end
    if (!memWant && $urandom_range(99) < memPct) begin
      memWant = 1; memWRd = pickRd(); memWData = $urandom;
    end
    alu_valid = aluWant;
    alu_rd    = aluWant ? aluWRd : 5'($urandom);
    alu_data  = aluWant ? aluWData : $urandom;
    mem_valid = memWant;
    mem_rd    = memWant ? memWRd : 5'($urandom);
    mem_data  = memWant ? memWData : $urandom;

    aluRdy = !portBusy(1'b0);
    memRdy = !portBusy(1'b1);
    inflightRd = '0;
    if (pend.size() > 0) begin
      g = pend.pop_front();
      if (g.rd != 5'd0) begin
        expQ.push_back(g);
        inflightRd = g.rd;
      end else if (expDrops < 255) begin
        expDrops++;
      end
    end
    if (memWant && memRdy) begin
      n.isMem = 1; n.rd = memWRd; n.data = memWData;
      pend.push_back(n);
      memWant = 0;
    end
    if (aluWant && aluRdy) begin
      n.isMem = 0; n.rd = aluWRd; n.data = aluWData;
      pend.push_back(n);
      aluWant = 0;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyStimulus();
    end
  endtask

  task automatic waitAccepted(input bit isMem);
    int cnt = 0;
    while ((isMem ? memWant : aluWant) && cnt < 8) begin
      runCycles(1);
      cnt++;
    end
    checkOutput("accept timeout", 32'(isMem ? memWant : aluWant), 32'd0);
  endtask

  task automatic drain();
    int cnt = 0;
    aluPct = 0; memPct = 0;
    while ((pend.size() > 0 || aluWant || memWant) && cnt < 20) begin
      runCycles(1);
      cnt++;
    end
    checkOutput("drain timeout", 32'(pend.size()), 32'd0);
    runCycles(2);
  endtask

  task automatic clearModel();
    pend.delete(); expQ.delete();
    expDrops = 0; inflightRd = '0; lastA3 = '0; lastWd = '0;
    aluWant = 0; memWant = 0;
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " alu_ready"}, 32'(alu_ready), 32'd1);
    checkOutput({tag, " mem_ready"}, 32'(mem_ready), 32'd1);
    checkOutput({tag, " we3"}, 32'(we3), 32'd0);
    checkOutput({tag, " a3"}, 32'(a3), 32'd0);
    checkOutput({tag, " wd3"}, wd3, 32'd0);
    checkOutput({tag, " pend_mask"}, pend_mask, 32'd0);
    checkOutput({tag, " x0_drops"}, 32'(x0_drops), 32'd0);
  endtask

  // Monitor: every write-port cycle is compared against the scoreboard;
  // idle cycles must hold the last written address/data.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (we3) begin
          if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected write: got a3=%0d wd3=%h expected no write at %0t", a3, wd3, $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("write a3", 32'(a3), 32'(e.rd));
            checkOutput("write wd3", wd3, e.data);
            lastA3 = e.rd;
            lastWd = e.data;
          end
        end else begin
          checkOutput("idle a3", 32'(a3), 32'(lastA3));
          checkOutput("idle wd3", wd3, lastWd);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus();

    // single write to x1
    aluWant = 1; aluWRd = 5'd1; aluWData = 32'hDEADBEEF;
    runCycles(4);

    // simultaneous requests: load unit first
    aluWant = 1; aluWRd = 5'd3; aluWData = 32'h11111111;
    memWant = 1; memWRd = 5'd4; memWData = 32'h22222222;
    runCycles(4);

    // same destination, acceptance order preserved
    aluWant = 1; aluWRd = 5'd5; aluWData = 32'hAAAAAAAA;
    runCycles(1);
    memWant = 1; memWRd = 5'd5; memWData = 32'hBBBBBBBB;
    runCycles(4);

    // single x0 write
    memWant = 1; memWRd = 5'd0; memWData = 32'hFFFFFFFF;
    drain();
    checkOutput("x0_drops single", 32'(x0_drops), 32'd1);

    // back-to-back ALU stream
    for (int i = 1; i <= 8; i++) begin
      aluWant = 1; aluWRd = 5'(i); aluWData = $urandom;
      waitAccepted(1'b0);
    end
    drain();

    aluPct = 60; memPct = 60;
    runCycles(2000);
    drain();

    for (int i = 0; i < 300; i++) begin
      memWant = 1; memWRd = 5'd0; memWData = 32'hFFFFFFFF;
      waitAccepted(1'b1);
    end
    drain();
    checkOutput("x0_drops saturated", 32'(x0_drops), 32'hFF);

    // reset with both buffers full
    aluWant = 1; aluWRd = 5'd7; aluWData = 32'h77777777;
    memWant = 1; memWRd = 5'd9; memWData = 32'h99999999;
    runCycles(1);
    @(posedge clk);
    #2;
    checkOutput("pre-reset alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("pre-reset mem_ready", 32'(mem_ready), 32'd0);
    rst_n = 1'b0;
    #1 checkResetOutputs("mid reset");
    clearModel();
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus();
    runCycles(3);

    aluPct = 50; memPct = 70;
    runCycles(300);
    drain();
    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
